// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into single APB4 transfers
// and returns each result on a valid/ready response channel. One transfer is
// outstanding at a time. Misaligned commands are rejected without bus activity,
// and ACCESS phases that stall too long are aborted by a wait-state timeout.
module apb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        pclk_i,
  input  logic        presetn_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_strb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic        pready_i,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  logic        cmd_ready_d;
  logic        rsp_valid_d;
  logic [31:0] rsp_rdata_d;
  logic        rsp_err_d;
  logic        rsp_timeout_d;
  logic [31:0] paddr_d;
  logic        psel_d;
  logic        penable_d;
  logic        pwrite_d;
  logic [31:0] pwdata_d;
  logic [3:0]  pstrb_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and next-output logic; every output register holds by default.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_o;
    rsp_valid_d   = rsp_valid_o;
    rsp_rdata_d   = rsp_rdata_o;
    rsp_err_d     = rsp_err_o;
    rsp_timeout_d = rsp_timeout_o;
    paddr_d       = paddr_o;
    psel_d        = psel_o;
    penable_d     = penable_o;
    pwrite_d      = pwrite_o;
    pwdata_d      = pwdata_o;
    pstrb_d       = pstrb_o;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          cmd_ready_d = 1'b0;
          if (cmd_addr_i[1:0] != 2'b00) begin
            // Misaligned: answer immediately with an error, no bus cycle.
            state_d       = ST_RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = 32'h0;
          end else begin
            state_d   = ST_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = cmd_addr_i;
            pwrite_d  = cmd_write_i;
            pwdata_d  = cmd_wdata_i;
            pstrb_d   = cmd_write_i ? cmd_strb_i : 4'h0;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ST_ACCESS: begin
        if (pready_i || (TO_EN && (cnt_inc == TO_LIMIT))) begin
          state_d       = ST_RESP;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          paddr_d       = 32'h0;
          pwrite_d      = 1'b0;
          pwdata_d      = 32'h0;
          pstrb_d       = 4'h0;
          if (pready_i) begin
            // Read data is only returned for a successful read.
            rsp_err_d     = pslverr_i;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = (!pwrite_o && !pslverr_i) ? prdata_i : 32'h0;
          end else begin
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = 32'h0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d       = ST_IDLE;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = 32'h0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cmd_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= 32'h0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      paddr_o       <= 32'h0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      pwdata_o      <= 32'h0;
      pstrb_o       <= 4'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_o   <= cmd_ready_d;
      rsp_valid_o   <= rsp_valid_d;
      rsp_rdata_o   <= rsp_rdata_d;
      rsp_err_o     <= rsp_err_d;
      rsp_timeout_o <= rsp_timeout_d;
      paddr_o       <= paddr_d;
      psel_o        <= psel_d;
      penable_o     <= penable_d;
      pwrite_o      <= pwrite_d;
      pwdata_o      <= pwdata_d;
      pstrb_o       <= pstrb_d;
    end
  end

endmodule
